// File: rtl/nios_handshake_mem_pkg.sv
// rtl/nios_handshake_mem_pkg.sv - shared widths, port index type and helpers for the NIOS/accelerator memory arbiter
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default word address and data widths
//   CNT_W                   : width of the optional grant/conflict counters
//   port_idx_t              : requester index (0 = CPU data master, 1 = handshake accelerator)
//   port_onehot()           : index to one-hot grant vector
package nios_handshake_mem_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 32;

    typedef logic port_idx_t;

    function automatic logic [1:0] port_onehot(input port_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/nios_handshake_rr_arb2.sv
// rtl/nios_handshake_rr_arb2.sv - two-way round-robin grant with a one-bit last_grant history
// Ports:
//   clk, reset : clock, synchronous active-high reset (last_grant returns to 1)
//   req[1:0]   : request per port
//   advance    : high in cycles where the grant is taken; updates last_grant
//   grant[1:0] : one-hot grant, or zero when idle or in reset
module nios_handshake_rr_arb2
    import nios_handshake_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    port_idx_t last_grant;

    // On a conflict the port that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = port_onehot(~last_grant);
                default: grant = 2'b00;
            endcase
        end
    end

    // Resetting to 1 lets port 0 win the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/nios_handshake_mem_arbiter.sv
// rtl/nios_handshake_mem_arbiter.sv - round-robin arbiter sharing one single-port RAM between CPU and accelerator
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   m0_* / m1_*         : Avalon-style requester ports (0 = CPU data master, 1 = handshake accelerator)
//                         address, byteenable, read, write, writedata in; readdata, waitrequest, readdatavalid out
//   mem_*               : RAM side; mem_readdata is the unregistered RAM output, valid one cycle after the address
//   gnt_cnt0/1,
//   conflict_cnt        : present only with NIOS_HANDSHAKE_MEM_ARB_PERF_EN defined
// Build option: NIOS_HANDSHAKE_MEM_ARB_PERF_EN adds wrapping per-port grant counters and a conflict counter.
module nios_handshake_mem_arbiter
    import nios_handshake_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,

`ifdef NIOS_HANDSHAKE_MEM_ARB_PERF_EN
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1,
    output logic [CNT_W-1:0]  conflict_cnt,
`endif

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       granted;
    port_idx_t  gnt_idx;
    logic       sel_read;
    logic       sel_write;
    logic       rd_accept;
    logic       rd_pending;
    port_idx_t  rd_owner;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign granted = |grant;
    assign gnt_idx = grant[1];

    nios_handshake_rr_arb2 u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (granted),
        .grant   (grant)
    );

    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];

    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        sel_read       = m0_read;
        sel_write      = m0_write;
        if (gnt_idx) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            sel_read       = m1_read;
            sel_write      = m1_write;
        end
    end

    assign mem_chipselect = granted;
    assign mem_write      = granted & sel_write;
    assign mem_clken      = 1'b1;

    // A simultaneous read+write is carried out as the write only; the read gets no response.
    assign rd_accept = granted & sel_read & ~sel_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= rd_accept;
            rd_owner   <= gnt_idx;
        end
    end

    // Reset also masks a response already in flight from the cycle before it asserted.
    assign m0_readdatavalid = rd_pending & ~reset & (rd_owner == 1'b0);
    assign m1_readdatavalid = rd_pending & ~reset & (rd_owner == 1'b1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

`ifdef NIOS_HANDSHAKE_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant[0]) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (grant[1]) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
            if (&req) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nios_handshake_mem_arbiter.sv
// tb/tb_nios_handshake_mem_arbiter.sv - self-checking bench for nios_handshake_mem_arbiter
module tb_nios_handshake_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, mem_readdata;
`ifdef NIOS_HANDSHAKE_MEM_ARB_PERF_EN
    logic [31:0]   gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    always #5 clk = ~clk;

    nios_handshake_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_readdata      (m0_readdata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_readdata      (m1_readdata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
`ifdef NIOS_HANDSHAKE_MEM_ARB_PERF_EN
        .gnt_cnt0         (gnt_cnt0),
        .gnt_cnt1         (gnt_cnt1),
        .conflict_cnt     (conflict_cnt),
`endif
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return {3'b000, a, 3'b101, ~a};
    endfunction

    // RAM with registered address and unregistered output.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic [AW-1:0] ram_aq = '0;
    logic          do_preload = 1'b0;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(AW'(i));
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_aq <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_aq];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst,
                         input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [BW-1:0] be0, input logic [DW-1:0] wd0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [BW-1:0] be1, input logic [DW-1:0] wd1);
        reset = rst;
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = wd0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = wd1;
    endtask

    typedef struct {
        logic          rst;
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        logic          xw0, xw1, xcs, xwe, xrv0, xrv1;
        logic [DW-1:0] xdata;
    } vec_t;

    function automatic vec_t mk(input logic rst,
                                input logic r0, input logic w0, input logic [AW-1:0] a0,
                                input logic r1, input logic w1, input logic [AW-1:0] a1,
                                input logic [BW-1:0] be, input logic [DW-1:0] wd,
                                input logic xw0, input logic xw1, input logic xcs, input logic xwe,
                                input logic xrv0, input logic xrv1, input logic [DW-1:0] xdata);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.be = be; v.wd = wd; v.xw0 = xw0; v.xw1 = xw1; v.xcs = xcs; v.xwe = xwe;
        v.xrv0 = xrv0; v.xrv1 = xrv1; v.xdata = xdata;
        return v;
    endfunction

    // Reference model state
    logic [DW-1:0] gold [0:DEPTH-1];
    int            m_last;
    bit            m_pend;
    int            m_owner;
    logic [DW-1:0] m_data;
    logic [31:0]   mc_gnt [2];
    logic [31:0]   mc_conf;

    initial begin
        vec_t          tv[$];
        logic [DW-1:0] p1fff;
        logic [DW-1:0] mix;
        bit            r[2], w[2], rq[2];
        logic [AW-1:0] a[2];
        logic [BW-1:0] be[2];
        logic [DW-1:0] wd[2];
        bit            rst;
        int            g;
        bit            ev[2];

        drive(1, 0,0,'0,'0,'0, 0,0,'0,'0,'0);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;

        p1fff = pat(13'h1FFF);
        mix   = {p1fff[31:16], 16'hBEEF};

        tv.push_back(mk(1, 1,0,13'h000, 1,0,13'h000, 4'hF,0, 1,1,0,0,0,0, 0));
        tv.push_back(mk(1, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,0,0, 0));
        tv.push_back(mk(0, 1,0,13'h010, 1,0,13'h020, 4'hF,0, 0,1,1,0,0,0, 0));
        tv.push_back(mk(0, 0,0,13'h000, 1,0,13'h020, 4'hF,0, 0,0,1,0,1,0, pat(13'h010)));
        tv.push_back(mk(0, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,0,1, pat(13'h020)));
        for (int k = 0; k < 6; k++) begin
            tv.push_back(mk(0, 1,0,13'h030, 1,0,13'h040, 4'hF,0,
                            (k % 2 == 1), (k % 2 == 0), 1, 0,
                            (k > 0 && k % 2 == 1), (k > 0 && k % 2 == 0),
                            (k % 2 == 1) ? pat(13'h030) : pat(13'h040)));
        end
        tv.push_back(mk(0, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,0,1, pat(13'h040)));
        tv.push_back(mk(0, 0,0,13'h000, 0,1,13'h1FFF, 4'b0011,32'hDEADBEEF, 0,0,1,1,0,0, 0));
        tv.push_back(mk(0, 1,0,13'h1FFF, 0,0,13'h000, 4'hF,0, 0,0,1,0,0,0, 0));
        tv.push_back(mk(0, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,1,0, mix));
        tv.push_back(mk(0, 1,0,13'h050, 0,0,13'h000, 4'hF,0, 0,0,1,0,0,0, 0));
        tv.push_back(mk(1, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,0,0, 0));
        tv.push_back(mk(0, 1,0,13'h060, 1,0,13'h070, 4'hF,0, 0,1,1,0,0,0, 0));
        tv.push_back(mk(0, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,1,0, pat(13'h060)));
        tv.push_back(mk(0, 1,1,13'h080, 0,0,13'h000, 4'hF,32'h12345678, 0,0,1,1,0,0, 0));
        tv.push_back(mk(0, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,0,0, 0));
        tv.push_back(mk(0, 1,0,13'h080, 0,0,13'h000, 4'hF,0, 0,0,1,0,0,0, 0));
        tv.push_back(mk(0, 0,0,13'h000, 0,0,13'h000, 4'hF,0, 0,0,0,0,1,0, 32'h12345678));

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].r0, tv[i].w0, tv[i].a0, tv[i].be, tv[i].wd,
                  tv[i].r1, tv[i].w1, tv[i].a1, tv[i].be, tv[i].wd);
            #2;
            chk($sformatf("v%0d_wait0", i), 32'(m0_waitrequest), 32'(tv[i].xw0));
            chk($sformatf("v%0d_wait1", i), 32'(m1_waitrequest), 32'(tv[i].xw1));
            chk($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(tv[i].xcs));
            chk($sformatf("v%0d_we", i), 32'(mem_write), 32'(tv[i].xwe));
            chk($sformatf("v%0d_rv0", i), 32'(m0_readdatavalid), 32'(tv[i].xrv0));
            chk($sformatf("v%0d_rv1", i), 32'(m1_readdatavalid), 32'(tv[i].xrv1));
            if (tv[i].xrv0) chk($sformatf("v%0d_rdata0", i), m0_readdata, tv[i].xdata);
            if (tv[i].xrv1) chk($sformatf("v%0d_rdata1", i), m1_readdata, tv[i].xdata);
        end

        // Randomized phase against the reference model.
        @(negedge clk);
        drive(1, 0,0,'0,'0,'0, 0,0,'0,'0,'0);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
        for (int i = 0; i < DEPTH; i++) gold[i] = pat(AW'(i));
        m_last = 1; m_pend = 0; m_owner = 0; m_data = '0;
        mc_gnt[0] = 0; mc_gnt[1] = 0; mc_conf = 0;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < 2; p++) begin
                int sel;
                sel   = $urandom_range(0, 9);
                r[p]  = (sel < 5) || (sel == 9);
                w[p]  = (sel >= 5 && sel < 8) || (sel == 9);
                a[p]  = AW'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 3) == 0) a[p] = 13'h1FFF;
                be[p] = BW'($urandom_range(0, 15));
                wd[p] = $urandom;
                rq[p] = r[p] || w[p];
            end
            drive(rst, r[0], w[0], a[0], be[0], wd[0], r[1], w[1], a[1], be[1], wd[1]);
            #2;

            if (rst)                g = -1;
            else if (rq[0] && rq[1]) g = 1 - m_last;
            else if (rq[0])          g = 0;
            else if (rq[1])          g = 1;
            else                     g = -1;

            ev[0] = !rst && m_pend && (m_owner == 0);
            ev[1] = !rst && m_pend && (m_owner == 1);

            chk("rnd_wait0", 32'(m0_waitrequest), 32'(rq[0] && g != 0));
            chk("rnd_wait1", 32'(m1_waitrequest), 32'(rq[1] && g != 1));
            chk("rnd_cs", 32'(mem_chipselect), 32'(g >= 0));
            chk("rnd_we", 32'(mem_write), 32'(g >= 0 && w[g >= 0 ? g : 0]));
            chk("rnd_rv0", 32'(m0_readdatavalid), 32'(ev[0]));
            chk("rnd_rv1", 32'(m1_readdatavalid), 32'(ev[1]));
            if (g >= 0) chk("rnd_addr", 32'(mem_address), 32'(a[g]));
            if (ev[0]) chk("rnd_rdata0", m0_readdata, m_data);
            if (ev[1]) chk("rnd_rdata1", m1_readdata, m_data);

            if (rst) begin
                m_last = 1; m_pend = 0;
                mc_gnt[0] = 0; mc_gnt[1] = 0; mc_conf = 0;
            end else begin
                if (rq[0] && rq[1]) mc_conf = mc_conf + 1;
                m_pend = 0;
                if (g >= 0) begin
                    m_last    = g;
                    mc_gnt[g] = mc_gnt[g] + 1;
                    if (w[g]) begin
                        for (int b = 0; b < BW; b++)
                            if (be[g][b]) gold[a[g]][8*b +: 8] = wd[g][8*b +: 8];
                    end else begin
                        m_pend  = 1;
                        m_owner = g;
                        m_data  = gold[a[g]];
                    end
                end
            end
        end

`ifdef NIOS_HANDSHAKE_MEM_ARB_PERF_EN
        @(negedge clk);
        drive(0, 0,0,'0,'0,'0, 0,0,'0,'0,'0);
        #2;
        chk("perf_gnt_cnt0", gnt_cnt0, mc_gnt[0]);
        chk("perf_gnt_cnt1", gnt_cnt1, mc_gnt[1]);
        chk("perf_conflict_cnt", conflict_cnt, mc_conf);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_handshake_mem_arbiter.md
NIOS_HANDSHAKE_MEM_ARBITER -- requirements
Module: nios_handshake_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 13, word address width; DATA_W, 32, data width; BE_W, DATA_W/8, byteenable width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. The ports are named clk and reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 For each requester port I in {0,1} (0 = CPU data master, 1 = handshake accelerator) the block SHALL have:
- mI_address  input  ADDR_W  word address.
- mI_byteenable  input  BE_W  byte lanes.
- mI_read  input  1  read request.
- mI_write  input  1  write request.
- mI_writedata  input  DATA_W  write data.
- mI_readdata  output  DATA_W  read data.
- mI_waitrequest  output  1  stall.
- mI_readdatavalid  output  1  read data strobe.
REQ-006 Memory-side ports SHALL be:
- mem_address  output  ADDR_W.
- mem_byteenable  output  BE_W.
- mem_chipselect  output  1.
- mem_write  output  1.
- mem_writedata  output  DATA_W.
- mem_clken  output  1.
- mem_readdata  input  DATA_W (unregistered RAM output; valid 1 cycle after address is presented).

Function
REQ-007 Requester I SHALL be "requesting" when mI_read | mI_write is high. At most one requester SHALL be granted per cycle.
REQ-008 Arbitration SHALL be round-robin via a 1-bit last_grant register:
- A sole requester is granted.
- On conflict, the requester != last_grant is granted.
- last_grant updates to the granted index on each grant and holds when idle.
REQ-009 mI_waitrequest SHALL equal requesting_I & ~grant_I (combinational); a transaction is accepted in the cycle its waitrequest is low.
REQ-010 Granted cycle SHALL drive:
- mem_chipselect = 1.
- mem_write = mI_write.
- mem_address, mem_byteenable, mem_writedata from port I.
With no grant, mem_chipselect = 0 and mem_write = 0.
REQ-011 If mI_read and mI_write are both high, the write SHALL be performed and the read dropped (no readdatavalid); the simulation model flags an error.
REQ-012 Writes SHALL complete in the grant cycle; no response is issued.
REQ-013 A read accepted in cycle N SHALL set registered rd_pending = 1 and rd_owner = I. In cycle N+1, mI_readdatavalid SHALL be 1 only for port rd_owner. Read latency is fixed at 1.
REQ-014 mI_readdata SHALL equal mem_readdata continuously for both ports; it is qualified only by readdatavalid.
REQ-015 Back-to-back reads, including alternating owners, SHALL sustain one transaction per cycle with no bubbles. rd_pending/rd_owner reload every cycle.
REQ-016 mem_clken SHALL be held at 1.

Reset
REQ-017 While reset is high at a clock edge, the following SHALL clear:
- last_grant = 1 (port 0 wins the first conflict).
- rd_pending = 0, so both readdatavalid are 0 in the next cycle.
- Counters (if present) = 0.
REQ-018 While reset is high, no grant SHALL be issued: both waitrequest = requesting, mem_chipselect = 0, mem_write = 0. A read accepted in the cycle before reset asserts SHALL NOT return readdatavalid.

Configuration
REQ-019 With macro NIOS_HANDSHAKE_MEM_ARB_PERF_EN defined, the block SHALL add outputs gnt_cnt0 and gnt_cnt1 (32-bit).
- Each counter increments by 1 per accepted transaction of its port and wraps from 0xFFFFFFFF to 0.
- A third 32-bit output, conflict_cnt, increments on each cycle where both ports request, and wraps the same way.
REQ-020 Without the macro, these ports and their registers SHALL be absent. Arbitration behaviour is identical in both builds.

Structure
REQ-021 Package nios_handshake_mem_pkg SHALL hold ADDR_W/DATA_W defaults, the port index type (1-bit), and the counter width constant.
REQ-022 The round-robin grant logic SHALL be sub-module nios_handshake_rr_arb2: inputs req[1:0], clk, reset, advance; output grant[1:0] (one-hot or zero).

Verification
REQ-023 After reset, m0 and m1 both read in the same cycle (addresses 0x010 and 0x020) ->
- cycle 0: grant m0, m1_waitrequest = 1.
- cycle 1: m0_readdatavalid with mem[0x010], grant m1.
- cycle 2: m1_readdatavalid with mem[0x020].
REQ-024 Both ports hold continuous reads for 6 cycles -> grants strictly alternate 0,1,0,1,0,1 and 6 readdatavalid pulses are returned to the correct owners.
REQ-025 m1 writes 0xDEADBEEF, byteenable 4'b0011, to 0x1FFF; m0 then reads 0x1FFF -> data low half = 0xBEEF, upper bytes unchanged.
REQ-026 m0 read accepted, then reset asserted in the following cycle -> no readdatavalid. After release, last_grant = 1 and a conflict grants m0.
REQ-027 With NIOS_HANDSHAKE_MEM_ARB_PERF_EN, 3 m0 and 5 m1 transactions with 2 conflict cycles -> gnt_cnt0 = 3, gnt_cnt1 = 5, conflict_cnt = 2. A preset of 0xFFFFFFFF wraps to 0 on the next grant.
